alu_pipe: RTL and testbench
===========================

# alu_pipe

Pipelined, parametrised arithmetic/logic unit with valid/ready handshakes on input and output, an internal accumulator and a sticky overflow flag. It replaces the combinational 2-bit-opcode ALU in the datapath. It adds a clocked two-stage pipeline, back-pressure, wider operands, logic ops and accumulate mode. The result register has exactly one driver: a single clocked process in stage 2.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/opcode present
- in_ready  out  1  block can accept this cycle
- op  in  3  operation code (see Operation)
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- result  out  WIDTH+1  operation result
- acc_ovf  out  1  sticky accumulator overflow

## Operation
- Opcodes:
  - 000 ADD: result = a + b, zero-extended to WIDTH+1 (bit WIDTH = carry).
  - 001 OR: result = {0, a|b}.
  - 010 SUB: result = a − b, computed mod 2^(WIDTH+1); bit WIDTH = 1 iff a < b (borrow).
  - 011 ADD: same as 000 (legacy encoding, kept).
  - 100 AND: result = {0, a&b}.
  - 101 XOR: result = {0, a^b}.
  - 110 ACC: acc ← acc + {0,a}, computed mod 2^(WIDTH+1); result = new acc.
  - 111 CLR: acc ← 0; acc_ovf ← 0; result = 0.
- b is ignored for ACC and CLR.
- Accumulator: internal WIDTH+1-bit register, not directly visible.
  - acc_ovf sets when an ACC add carries out of bit WIDTH; the acc value wraps.
  - acc_ovf holds until CLR or reset.
- Stage 1 (S1): on accept (in_valid && in_ready), register op, a, b and set s1_valid.
- Stage 2 (S2): on advance, compute from the S1 registers into result and set out_valid = s1_valid.
  - acc and acc_ovf update only when an ACC/CLR transaction moves S1→S2.
- Global advance = !out_valid || out_ready.
  - On advance, both stages shift.
  - Without advance, all pipeline registers, acc and acc_ovf hold.
- in_ready = advance, a combinational function of out_valid and out_ready only. It never depends on in_valid.
- When S1 shifts with no new accept, s1_valid ← 0 (bubble).
- Output stability: while out_valid && !out_ready, result is held unchanged.
- Operations are applied strictly in acceptance order. Back-to-back ACC ops chain through acc with no hazard, because acc updates at the S1→S2 transfer.

## Timing
- Reset (asynchronous, any time, including mid-stall):
  - s1_valid = 0, out_valid = 0, result = 0, acc = 0, acc_ovf = 0.
  - in_ready = 1 immediately after reset, because out_valid = 0.
  - In-flight transactions are discarded.
- Latency: a transaction accepted at edge N appears with out_valid = 1 after edge N+1, given no stall.
- Throughput: 1 transaction/cycle while out_ready = 1.
- Stall: with out_valid = 1 and out_ready = 0, in_ready = 0 in the same cycle. No input is accepted and nothing is lost.
  - The S1 content is retained and moves to S2 on the first cycle with out_ready = 1.
- Pipeline holds at most 2 transactions. There is no skid buffer: throughput under back-pressure is limited by the combinational in_ready path.
- Simultaneous out_ready = 1 and in_valid = 1 with a full pipeline: the output retires, S1 moves to S2, and the new input enters S1, all at the same edge.
- result and out_valid are registers. No combinational path exists from inputs to result.

## Test plan
- Reset then idle: rst_n low mid-cycle → all outputs 0, in_ready = 1 asynchronously; no out_valid for ≥5 cycles with in_valid = 0.
- Ops sweep (WIDTH=4, out_ready = 1):
  - ADD a=9,b=8 → 17 (5'b10001)
  - OR 5|10 → 15
  - SUB 3−5 → 5'b11110 (borrow = 1)
  - AND 12&10 → 8
  - XOR 12^10 → 6
  - op 011 with 15+15 → 30
  - each result appears two edges after acceptance.
- Accumulate and overflow:
  - CLR, then ACC a=15 four times back-to-back → results 15, 30, 13, 28.
  - acc_ovf rises with the third result and stays 1.
  - CLR → result 0, acc_ovf = 0.
- Back-pressure:
  - stream ADD 1+1, 2+2, 3+3; hold out_ready = 0 for 4 cycles after the first result.
  - result stays 2; in_ready = 0 during the stall.
  - after release, the outputs are exactly 2, 4, 6 in order, with no duplicates or loss.
- Streaming: in_valid and out_ready held at 1 for 16 random ops → 16 results on 16 consecutive cycles after a 2-cycle fill, matching a reference model.
- Reset mid-stall: pipeline full and stalled with ACC pending; assert rst_n = 0 → out_valid = 0, acc = 0 (a subsequent ACC a=3 returns 3), acc_ovf = 0.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe - two-stage pipelined ALU with valid/ready handshakes, an
// internal accumulator and a sticky accumulator-overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/opcode present
//   in_ready   block can accept this cycle (= !out_valid || out_ready)
//   op[2:0]    000/011 ADD, 001 OR, 010 SUB, 100 AND, 101 XOR, 110 ACC, 111 CLR
//   a, b       unsigned operands, WIDTH bits (b ignored by ACC/CLR)
//   out_valid  result present
//   out_ready  consumer accepts result
//   result     WIDTH+1 bit result (bit WIDTH = carry / borrow)
//   acc_ovf    sticky accumulator overflow, cleared by CLR or reset
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             acc_ovf
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_OR   = 3'b001,
    OP_SUB  = 3'b010,
    OP_ADD2 = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_ACC  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH:0]   r_acc;

  logic             w_advance;
  logic [WIDTH:0]   w_result;
  logic [WIDTH:0]   w_acc_next;
  logic             w_ovf_next;
  logic [WIDTH+1:0] w_acc_sum;

  // Both stages shift together whenever the output slot is free or being
  // consumed; there is no skid buffer, so in_ready is exactly this term.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // One extra bit keeps the carry out of bit WIDTH for overflow detection.
  assign w_acc_sum = {1'b0, r_acc} + {2'b00, r_s1_a};

  always_comb begin
    w_result   = '0;
    w_acc_next = r_acc;
    w_ovf_next = acc_ovf;
    unique case (r_s1_op)
      OP_ADD, OP_ADD2: w_result = {1'b0, r_s1_a} + {1'b0, r_s1_b};
      OP_OR:           w_result = {1'b0, r_s1_a | r_s1_b};
      // Mod 2^(WIDTH+1) subtraction leaves bit WIDTH set exactly on borrow.
      OP_SUB:          w_result = {1'b0, r_s1_a} - {1'b0, r_s1_b};
      OP_AND:          w_result = {1'b0, r_s1_a & r_s1_b};
      OP_XOR:          w_result = {1'b0, r_s1_a ^ r_s1_b};
      OP_ACC: begin
        w_acc_next = w_acc_sum[WIDTH:0];
        w_ovf_next = acc_ovf | w_acc_sum[WIDTH+1];
        w_result   = w_acc_sum[WIDTH:0];
      end
      OP_CLR: begin
        w_acc_next = '0;
        w_ovf_next = 1'b0;
        w_result   = '0;
      end
      default: w_result = '0;
    endcase
  end

  // Stage 1: capture the operands on accept; a shift without accept
  // leaves a bubble behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= op_e'(op);
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  // Stage 2: the only writer of result and the accumulator state. acc and
  // acc_ovf change only as a valid transaction moves out of stage 1, so
  // back-to-back ACC ops chain without a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      r_acc     <= '0;
      acc_ovf   <= 1'b0;
    end else if (w_advance) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        result  <= w_result;
        r_acc   <= w_acc_next;
        acc_ovf <= w_ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  logic       clk;
  logic       rstN;
  logic       inValid;
  logic       inReady;
  logic [2:0] opIn;
  logic [3:0] aIn;
  logic [3:0] bIn;
  logic       outValid;
  logic       outReady;
  logic [4:0] result;
  logic       accOvf;

  alu_pipe #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .op        (opIn),
    .a         (aIn),
    .b         (bIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .acc_ovf   (accOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] expRes;
    logic       expOvf;
  } vecT;

  typedef struct {
    logic [4:0] res;
    logic       ovf;
  } expT;

  expT sbQ[$];
  vecT vecs[12];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int lastPopCycle = -10;
  int run = 0;
  int maxRun = 0;

  // Reference accumulator state kept independently of the DUT.
  logic [4:0] mAcc = '0;
  logic       mOvf = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model of one operation, advancing the model accumulator.
  task automatic modelStep(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           output logic [4:0] res, output logic ovf);
    logic [5:0] s;
    case (op)
      3'b000, 3'b011: res = {1'b0, a} + {1'b0, b};
      3'b001: res = {1'b0, a | b};
      3'b010: res = {1'b0, a} - {1'b0, b};
      3'b100: res = {1'b0, a & b};
      3'b101: res = {1'b0, a ^ b};
      3'b110: begin
        s = {1'b0, mAcc} + {2'b00, a};
        mAcc = s[4:0];
        if (s[5]) mOvf = 1'b1;
        res = mAcc;
      end
      default: begin
        mAcc = '0;
        mOvf = 1'b0;
        res = '0;
      end
    endcase
    ovf = mOvf;
  endtask

  // Presents one transaction and holds it until accepted; the expectation
  // is queued at the moment acceptance is certain, preserving order.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic [4:0] expRes, input logic expOvf);
    bit accepted = 0;
    expT e;
    inValid = 1'b1;
    opIn = op;
    aIn = a;
    bIn = b;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      if (inReady) begin
        e.res = expRes;
        e.ovf = expOvf;
        sbQ.push_back(e);
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("acceptTimeout", 0, 1);
    inValid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sbQ.size() != 0; k++) @(posedge clk);
    #1;
    checkOutput("drainEmpty", sbQ.size(), 0);
  endtask

  // Scoreboard monitor: a handshake seen at the negedge completes at the
  // following posedge, so the oldest expectation is compared here.
  always @(negedge clk) begin
    expT e;
    if (rstN === 1'b1 && outValid === 1'b1 && outReady === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedOutput", int'(result), -1);
      end else begin
        e = sbQ.pop_front();
        checkOutput("result", int'(result), int'(e.res));
        checkOutput("accOvf", int'(accOvf), int'(e.ovf));
      end
      if (cycle == lastPopCycle + 1) run++;
      else run = 1;
      lastPopCycle = cycle;
      if (run > maxRun) maxRun = run;
    end
  end

  initial begin
    logic [4:0] r;
    logic o;
    logic [2:0] rop;
    logic [3:0] ra, rb;
    bit seen;

    vecs[0]  = '{3'b000, 4'd9,  4'd8,  5'd17, 1'b0};
    vecs[1]  = '{3'b001, 4'd5,  4'd10, 5'd15, 1'b0};
    vecs[2]  = '{3'b010, 4'd3,  4'd5,  5'd30, 1'b0};
    vecs[3]  = '{3'b100, 4'd12, 4'd10, 5'd8,  1'b0};
    vecs[4]  = '{3'b101, 4'd12, 4'd10, 5'd6,  1'b0};
    vecs[5]  = '{3'b011, 4'd15, 4'd15, 5'd30, 1'b0};
    vecs[6]  = '{3'b111, 4'd0,  4'd0,  5'd0,  1'b0};
    vecs[7]  = '{3'b110, 4'd15, 4'd0,  5'd15, 1'b0};
    vecs[8]  = '{3'b110, 4'd15, 4'd0,  5'd30, 1'b0};
    vecs[9]  = '{3'b110, 4'd15, 4'd0,  5'd13, 1'b1};
    vecs[10] = '{3'b110, 4'd15, 4'd0,  5'd28, 1'b1};
    vecs[11] = '{3'b111, 4'd0,  4'd0,  5'd0,  1'b0};

    rstN = 1'b1;
    inValid = 1'b0;
    opIn = '0;
    aIn = '0;
    bIn = '0;
    outReady = 1'b1;

    // Reset asserted mid-cycle takes effect without a clock edge.
    #13 rstN = 1'b0;
    #1;
    checkOutput("rstOutValid", int'(outValid), 0);
    checkOutput("rstResult", int'(result), 0);
    checkOutput("rstAccOvf", int'(accOvf), 0);
    checkOutput("rstInReady", int'(inReady), 1);
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("idleOutValid", int'(outValid), 0);
    end
    @(posedge clk);
    #1;

    // Ops sweep and accumulate sequence; the first row also checks latency.
    for (int i = 0; i < 12; i++) begin
      modelStep(vecs[i].op, vecs[i].a, vecs[i].b, r, o);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expOvf);
      if (i == 0) begin
        checkOutput("latencyNotYet", int'(outValid), 0);
        @(posedge clk);
        #1;
        checkOutput("latencyValid", int'(outValid), 1);
        checkOutput("latencyResult", int'(result), 17);
      end
    end
    drain();

    // Back-pressure: stall four cycles once the first result shows.
    fork
      begin
        applyStimulus(3'b000, 4'd1, 4'd1, 5'd2, 1'b0);
        applyStimulus(3'b000, 4'd2, 4'd2, 5'd4, 1'b0);
        applyStimulus(3'b000, 4'd3, 4'd3, 5'd6, 1'b0);
      end
      begin
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(posedge clk);
          #1;
          if (outValid) seen = 1;
        end
        if (!seen) checkOutput("bpFirstTimeout", 0, 1);
        outReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checkOutput("bpHoldResult", int'(result), 2);
          checkOutput("bpHoldValid", int'(outValid), 1);
          checkOutput("bpInReady", int'(inReady), 0);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    drain();

    // Streaming: 16 back-to-back random ops against the model.
    repeat (3) @(posedge clk);
    #1;
    maxRun = 0;
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      modelStep(rop, ra, rb, r, o);
      applyStimulus(rop, ra, rb, r, o);
    end
    drain();
    checkOutput("streamRun", maxRun, 16);

    // Reset mid-stall: set acc_ovf, then fill and stall with ACC pending.
    modelStep(3'b111, 4'd0, 4'd0, r, o);
    applyStimulus(3'b111, 4'd0, 4'd0, r, o);
    for (int i = 0; i < 3; i++) begin
      modelStep(3'b110, 4'd15, 4'd0, r, o);
      applyStimulus(3'b110, 4'd15, 4'd0, r, o);
    end
    drain();
    checkOutput("preStallOvf", int'(accOvf), 1);
    outReady = 1'b0;
    inValid = 1'b1;
    opIn = 3'b110;
    aIn = 4'd5;
    @(posedge clk);
    #1;
    aIn = 4'd6;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("stallFullValid", int'(outValid), 1);
    checkOutput("stallInReady", int'(inReady), 0);
    @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("midRstOutValid", int'(outValid), 0);
    checkOutput("midRstResult", int'(result), 0);
    checkOutput("midRstAccOvf", int'(accOvf), 0);
    checkOutput("midRstInReady", int'(inReady), 1);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b1;
    mAcc = '0;
    mOvf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("postRstIdle", int'(outValid), 0);
    end
    @(posedge clk);
    #1;
    modelStep(3'b110, 4'd3, 4'd0, r, o);
    applyStimulus(3'b110, 4'd3, 4'd0, 5'd3, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
